alu_cmd_sequencer: RTL

//  Command-side master for the combinational ALU: accepts register-to-register ALU commands over valid/ready,

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_regfile.sv | 39 +++
 rtl/alu_cmd_sequencer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Opcode and sequencer-state definitions shared by the ALU command sequencer and the ALU it drives.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_LDI = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } seq_state_t;

    function automatic logic is_ldi(input logic [2:0] op);
        return op == OP_LDI;
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file: two async operand read ports, an async debug port and one sync write port.
// Register 0 is hardwired to zero; the whole array clears synchronously on rst.
module alu_regfile
    import alu_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int NREGS = 8,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr_a,
    output logic [WIDTH-1:0] o_rdata_a,
    input  logic [AW-1:0]    i_raddr_b,
    output logic [WIDTH-1:0] o_rdata_b,
    input  logic [AW-1:0]    i_dbg_addr,
    output logic [WIDTH-1:0] o_dbg_data
);

    logic [WIDTH-1:0] r_mem [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (i_waddr != '0)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a  = (i_raddr_a  == '0) ? '0 : r_mem[i_raddr_a];
    assign o_rdata_b  = (i_raddr_b  == '0) ? '0 : r_mem[i_raddr_b];
    assign o_dbg_data = (i_dbg_addr == '0) ? '0 : r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command-side master for a combinational ALU: reads operands, drives the ALU, writes the
// result back to the register file and returns it on a valid/ready response channel.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int NREGS = 8,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [AW-1:0]    cmd_rd,
    input  logic [AW-1:0]    cmd_ra,
    input  logic [AW-1:0]    cmd_rb,
    input  logic [WIDTH-1:0] cmd_imm,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic [AW-1:0]    rsp_rd,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    seq_state_t       r_state;
    logic             r_cmd_ready;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [2:0]       r_alu_op;
    logic [WIDTH-1:0] r_imm;
    logic [AW-1:0]    r_rd;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_result;
    logic             r_rsp_zero;
    logic [AW-1:0]    r_rsp_rd;

    logic [WIDTH-1:0] w_rdata_a;
    logic [WIDTH-1:0] w_rdata_b;
    logic             w_we;
    logic [WIDTH-1:0] w_wdata;
    logic             w_wzero;

    // LDI bypasses the ALU: the latched immediate is the writeback value.
    assign w_wdata = is_ldi(r_alu_op) ? r_imm : alu_result;
    assign w_wzero = is_ldi(r_alu_op) ? (r_imm == '0) : alu_zero;
    assign w_we    = (r_state == ST_EXEC);

    alu_regfile #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .i_we       (w_we),
        .i_waddr    (r_rd),
        .i_wdata    (w_wdata),
        .i_raddr_a  (cmd_ra),
        .o_rdata_a  (w_rdata_a),
        .i_raddr_b  (cmd_rb),
        .o_rdata_b  (w_rdata_b),
        .i_dbg_addr (dbg_addr),
        .o_dbg_data (dbg_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cmd_ready  <= 1'b1;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_op     <= '0;
            r_imm        <= '0;
            r_rd         <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b0;
            r_rsp_rd     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid && r_cmd_ready) begin
                        r_alu_a     <= w_rdata_a;
                        r_alu_b     <= w_rdata_b;
                        r_alu_op    <= cmd_op;
                        r_imm       <= cmd_imm;
                        r_rd        <= cmd_rd;
                        r_cmd_ready <= 1'b0;
                        r_state     <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_rsp_result <= w_wdata;
                    r_rsp_zero   <= w_wzero;
                    r_rsp_rd     <= r_rd;
                    r_rsp_valid  <= 1'b1;
                    r_state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready  = r_cmd_ready;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_op     = r_alu_op;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign rsp_zero   = r_rsp_zero;
    assign rsp_rd     = r_rsp_rd;

endmodule
